// File: rtl/aes_block_packer.sv
// ---------------------------------------------------------------------------
// aes_block_packer
//
// Upstream feeder for the AES-CBC engine. Packs a 32-bit byte stream into
// 128-bit plaintext blocks and closes each message with either PKCS#7
// padding or zero fill, so the engine only ever receives whole blocks.
// Filling and emitting never overlap: the packer either accepts input
// words (FILL) or presents a finished block (EMIT / EMIT_PAD).
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   clear_i      synchronous soft clear (same effect as reset)
//   enable_i     global enable; low freezes every register and both
//                handshakes
//   pad_en_i     1 = PKCS#7 padding, 0 = zero-fill of a partial tail;
//                sampled on the accept of the last word only
//   in_data_i    input word, first byte in [31:24]
//   in_strb_i    byte valid mask, bit 3 covers [31:24]
//   in_last_i    final word of the message
//   in_valid_i   input valid
//   in_ready_o   input ready (FILL state only)
//   out_data_o   registered block, first byte in [127:120]
//   out_last_o   block is the final block of its message
//   out_valid_o  output valid (EMIT / EMIT_PAD states only)
//   out_ready_i  output ready
//   blk_cnt_o    blocks handed off since reset/clear, wraps at 2^CNT_W
//   err_o        sticky flag for an illegal strobe pattern
// ---------------------------------------------------------------------------
module aes_block_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             pad_en_i,
    input  logic [31:0]      in_data_i,
    input  logic [3:0]       in_strb_i,
    input  logic             in_last_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [127:0]     out_data_o,
    output logic             out_last_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] blk_cnt_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT     = 2'd1,
        EMIT_PAD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [127:0]       r_blk;
    logic [127:0]       w_blkNext;
    logic [4:0]         r_bcnt;
    logic [4:0]         w_bcntNext;
    logic               r_last;
    logic               w_lastNext;
    logic               r_padPending;
    logic               w_padPendingNext;
    logic [CNT_W-1:0]   r_blkCnt;
    logic [CNT_W-1:0]   w_blkCntNext;
    logic               r_err;
    logic               w_errNext;

    logic               w_accept;
    logic               w_handshake;
    logic               w_strbLegal;
    logic [2:0]         w_nBytes;
    logic [4:0]         w_fillEnd;
    logic [7:0]         w_padByte;
    logic [127:0]       w_merged;

    // Both handshakes are qualified by state and enable only; out_valid_o
    // never looks at out_ready_i. Reset also forces the readies/valids low
    // while it is asserted.
    assign in_ready_o  = ~rst_i & enable_i & (r_state == FILL);
    assign out_valid_o = ~rst_i & enable_i & (r_state != FILL);

    assign out_data_o  = r_blk;
    assign out_last_o  = r_last;
    assign blk_cnt_o   = r_blkCnt;
    assign err_o       = r_err;

    assign w_accept    = in_valid_i & in_ready_o;
    assign w_handshake = out_valid_o & out_ready_i;

    // Strobe decode. A last word may carry a left-aligned run of 1..4
    // bytes; every other word must be full. Anything illegal is taken as
    // a full word and raises the sticky error.
    always_comb begin
        w_strbLegal = 1'b0;
        w_nBytes    = 3'd4;
        if (in_last_i) begin
            case (in_strb_i)
                4'b1000: begin w_strbLegal = 1'b1; w_nBytes = 3'd1; end
                4'b1100: begin w_strbLegal = 1'b1; w_nBytes = 3'd2; end
                4'b1110: begin w_strbLegal = 1'b1; w_nBytes = 3'd3; end
                4'b1111: begin w_strbLegal = 1'b1; w_nBytes = 3'd4; end
                default: begin w_strbLegal = 1'b0; w_nBytes = 3'd4; end
            endcase
        end else begin
            w_strbLegal = (in_strb_i == 4'b1111);
        end
    end

    assign w_fillEnd = r_bcnt + {2'b00, w_nBytes};

    // Tail byte for a last word that leaves the block short: PKCS#7 puts
    // the count of missing bytes in every missing byte.
    assign w_padByte = pad_en_i ? {3'b000, 5'd16 - w_fillEnd} : 8'h00;

    // Block image after writing the incoming word. In FILL the byte count
    // is always a multiple of four (a short word is always the last one and
    // leaves FILL), so byte i of the block takes word byte i%4. Bytes past
    // the written ones are padded only when this word ends the message.
    always_comb begin
        w_merged = r_blk;
        for (int i = 0; i < 16; i++) begin
            if ((5'(i) >= r_bcnt) && (5'(i) < w_fillEnd)) begin
                w_merged[127-8*i -: 8] = in_data_i[31-8*(i%4) -: 8];
            end else if (in_last_i && (5'(i) >= w_fillEnd)) begin
                w_merged[127-8*i -: 8] = w_padByte;
            end
        end
    end

    // Next-state logic. Every register holds by default; a full aligned
    // last block with padding enabled leaves a pending flag so that a
    // standalone pad block follows it.
    always_comb begin
        w_stateNext      = r_state;
        w_blkNext        = r_blk;
        w_bcntNext       = r_bcnt;
        w_lastNext       = r_last;
        w_padPendingNext = r_padPending;
        w_blkCntNext     = r_blkCnt;
        w_errNext        = r_err;

        case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_blkNext  = w_merged;
                    w_bcntNext = w_fillEnd;
                    if (!w_strbLegal) begin
                        w_errNext = 1'b1;
                    end
                    if (in_last_i) begin
                        w_stateNext = EMIT;
                        if ((w_fillEnd == 5'd16) && pad_en_i) begin
                            w_lastNext       = 1'b0;
                            w_padPendingNext = 1'b1;
                        end else begin
                            w_lastNext       = 1'b1;
                            w_padPendingNext = 1'b0;
                        end
                    end else if (w_fillEnd == 5'd16) begin
                        w_stateNext = EMIT;
                        w_lastNext  = 1'b0;
                    end
                end
            end

            EMIT: begin
                if (w_handshake) begin
                    w_blkCntNext = r_blkCnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_padPending) begin
                        w_stateNext      = EMIT_PAD;
                        w_blkNext        = {16{8'h10}};
                        w_lastNext       = 1'b1;
                        w_padPendingNext = 1'b0;
                    end else begin
                        w_stateNext = FILL;
                        w_blkNext   = '0;
                        w_bcntNext  = '0;
                        w_lastNext  = 1'b0;
                    end
                end
            end

            EMIT_PAD: begin
                if (w_handshake) begin
                    w_blkCntNext = r_blkCnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    w_stateNext  = FILL;
                    w_blkNext    = '0;
                    w_bcntNext   = '0;
                    w_lastNext   = 1'b0;
                end
            end

            default: begin
                w_stateNext      = FILL;
                w_blkNext        = '0;
                w_bcntNext       = '0;
                w_lastNext       = 1'b0;
                w_padPendingNext = 1'b0;
            end
        endcase
    end

    // State register. Reset and clear discard any block in progress;
    // a low enable freezes everything exactly as it is.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state      <= FILL;
            r_blk        <= '0;
            r_bcnt       <= '0;
            r_last       <= 1'b0;
            r_padPending <= 1'b0;
            r_blkCnt     <= '0;
            r_err        <= 1'b0;
        end else if (enable_i) begin
            r_state      <= w_stateNext;
            r_blk        <= w_blkNext;
            r_bcnt       <= w_bcntNext;
            r_last       <= w_lastNext;
            r_padPending <= w_padPendingNext;
            r_blkCnt     <= w_blkCntNext;
            r_err        <= w_errNext;
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// ---------------------------------------------------------------------------
// tb_aes_block_packer
//
// Self-checking bench for aes_block_packer. Messages are modelled as byte
// queues: every word pushed into the DUT also feeds the byte queue, full
// 16-byte groups and the padded tail become expected blocks, and a sink
// process compares every handed-off block against that list.
// ---------------------------------------------------------------------------
module tb_aes_block_packer;

    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             clear_i;
    logic             enable_i;
    logic             pad_en_i;
    logic [31:0]      in_data_i;
    logic [3:0]       in_strb_i;
    logic             in_last_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [127:0]     out_data_o;
    logic             out_last_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [CNT_W-1:0] blk_cnt_o;
    logic             err_o;

    int               checks   = 0;
    int               failures = 0;

    logic [7:0]       msgBytes[$];
    logic [127:0]     expQ[$];
    bit               expLastQ[$];
    int               tbBlocks = 0;
    int               sinkMode = 1;
    bit               jitter   = 1'b0;
    bit               prevStall = 1'b0;
    logic [127:0]     prevData;
    logic             prevLast;

    aes_block_packer #(.CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .enable_i    (enable_i),
        .pad_en_i    (pad_en_i),
        .in_data_i   (in_data_i),
        .in_strb_i   (in_strb_i),
        .in_last_i   (in_last_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .blk_cnt_o   (blk_cnt_o),
        .err_o       (err_o)
    );

    // 10 ns clock
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Turns the bytes of a message into expected blocks: every complete
    // group of 16 is a block; at the end of the message the short tail is
    // filled with PKCS#7 bytes or zeros, and an exactly aligned message
    // gets an extra all-0x10 block when padding is on.
    task automatic modelWord(input logic [31:0] d, input logic [3:0] s,
                             input bit l, input bit p);
        int nb;
        int r;
        logic [127:0] blk;
        nb = 4;
        if (l) begin
            case (s)
                4'b1000: nb = 1;
                4'b1100: nb = 2;
                4'b1110: nb = 3;
                default: nb = 4;
            endcase
        end
        for (int b = 0; b < nb; b++) msgBytes.push_back(d[31-8*b -: 8]);
        while (msgBytes.size() >= 16) begin
            for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = msgBytes.pop_front();
            expQ.push_back(blk);
            expLastQ.push_back(l && (msgBytes.size() == 0) && !p);
            tbBlocks++;
        end
        if (l) begin
            r = msgBytes.size();
            if (r > 0) begin
                for (int j = 0; j < 16; j++) begin
                    if (j < r) blk[127-8*j -: 8] = msgBytes[j];
                    else       blk[127-8*j -: 8] = p ? 8'(16 - r) : 8'h00;
                end
                expQ.push_back(blk);
                expLastQ.push_back(1'b1);
                tbBlocks++;
            end else if (p) begin
                expQ.push_back({16{8'h10}});
                expLastQ.push_back(1'b1);
                tbBlocks++;
            end
            msgBytes.delete();
        end
    endtask

    // Drives one word and waits (bounded) for it to be accepted. With
    // jitter on, enable is randomly dropped while waiting.
    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] s,
                                 input bit l, input bit p);
        bit acc;
        acc = 1'b0;
        modelWord(d, s, l, p);
        @(negedge clk_i);
        in_data_i  = d;
        in_strb_i  = s;
        in_last_i  = l;
        pad_en_i   = p;
        in_valid_i = 1'b1;
        for (int w = 0; w < 300 && !acc; w++) begin
            if (w > 0) @(negedge clk_i);
            enable_i = !(jitter && ($urandom % 6 == 0));
            #1;
            if (in_ready_o) acc = 1'b1;
        end
        if (acc) begin
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 1'b0;
        enable_i   = 1'b1;
        if (!acc) checkOutput("acceptTimeout", 128'(0), 128'(1));
    endtask

    // Waits (bounded) until every expected block has been handed off.
    task automatic waitDrain();
        int n;
        n = 0;
        enable_i = 1'b1;
        while (expQ.size() != 0 && n < 600) begin
            @(negedge clk_i);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drainTimeout", 128'(expQ.size()), 128'(0));
            expQ.delete();
            expLastQ.delete();
        end
        @(negedge clk_i);
        #3;
    endtask

    task automatic resetModel();
        msgBytes.delete();
        expQ.delete();
        expLastQ.delete();
        tbBlocks  = 0;
        prevStall = 1'b0;
    endtask

    // Output sink: chooses ready each cycle, checks stalled outputs hold
    // still and compares each handed-off block with the model.
    initial begin
        out_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            case (sinkMode)
                0:       out_ready_i = ($urandom % 3) != 0;
                1:       out_ready_i = 1'b1;
                default: out_ready_i = 1'b0;
            endcase
            #2;
            if (out_valid_o) begin
                if (prevStall) begin
                    checkOutput("holdData", out_data_o, prevData);
                    checkOutput("holdLast", 128'(out_last_o), 128'(prevLast));
                end
                if (out_ready_i) begin
                    if (expQ.size() == 0) begin
                        checkOutput("extraBlock", out_data_o, 128'(0));
                    end else begin
                        checkOutput("blockData", out_data_o, expQ.pop_front());
                        checkOutput("blockLast", 128'(out_last_o), 128'(expLastQ.pop_front()));
                    end
                    prevStall = 1'b0;
                end else begin
                    prevStall = 1'b1;
                    prevData  = out_data_o;
                    prevLast  = out_last_o;
                end
            end
        end
    end

    // Main sequence: directed test plan first, then random messages.
    initial begin
        int nWords;
        int cntBefore;
        logic [3:0] lastStrb;
        bit pad;

        rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1; pad_en_i = 1'b0;
        in_data_i = '0; in_strb_i = '0; in_last_i = 1'b0; in_valid_i = 1'b0;
        sinkMode = 1;

        repeat (3) @(negedge clk_i);
        #2;
        checkOutput("rstInReady", 128'(in_ready_o), 128'(0));
        checkOutput("rstOutValid", 128'(out_valid_o), 128'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        checkOutput("resetInReady", 128'(in_ready_o), 128'(1));
        checkOutput("resetOutValid", 128'(out_valid_o), 128'(0));
        checkOutput("resetOutData", out_data_o, 128'(0));
        checkOutput("resetOutLast", 128'(out_last_o), 128'(0));
        checkOutput("resetBlkCnt", 128'(blk_cnt_o), 128'(0));
        checkOutput("resetErr", 128'(err_o), 128'(0));

        // 32-byte aligned message with padding: two data blocks + pad block
        for (int i = 0; i < 8; i++)
            applyStimulus(32'h00010203 + 32'(i) * 32'h04040404, 4'b1111, i == 7, 1'b1);
        waitDrain();
        checkOutput("plan1BlkCnt", 128'(blk_cnt_o), 128'(3));

        // 5-byte message padded with eleven 0x0B
        applyStimulus(32'h00112233, 4'b1111, 1'b0, 1'b1);
        applyStimulus(32'h44AABBCC, 4'b1000, 1'b1, 1'b1);
        waitDrain();
        checkOutput("plan2BlkCnt", 128'(blk_cnt_o), 128'(4));

        // Same message zero-filled
        applyStimulus(32'h00112233, 4'b1111, 1'b0, 1'b0);
        applyStimulus(32'h44AABBCC, 4'b1000, 1'b1, 1'b0);
        waitDrain();
        checkOutput("plan3BlkCnt", 128'(blk_cnt_o), 128'(5));

        // Aligned 16-byte message, no padding: exactly one last block
        for (int i = 0; i < 4; i++)
            applyStimulus(32'hA0A1A2A3 + 32'(i), 4'b1111, i == 3, 1'b0);
        waitDrain();
        checkOutput("alignedBlkCnt", 128'(blk_cnt_o), 128'(6));

        // Output stall for 10 cycles with enable low for 3 of them
        sinkMode = 2;
        cntBefore = tbBlocks;
        for (int i = 0; i < 4; i++)
            applyStimulus(32'h5A5A0000 + 32'(i), 4'b1111, i == 3, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            enable_i = !(c >= 3 && c < 6);
            #2;
            checkOutput("stallInReady", 128'(in_ready_o), 128'(0));
            checkOutput("stallOutValid", 128'(out_valid_o), 128'(enable_i));
            checkOutput("stallData", out_data_o, expQ.size() > 0 ? expQ[0] : 128'(0));
        end
        enable_i = 1'b1;
        sinkMode = 1;
        waitDrain();
        checkOutput("stallBlkCnt", 128'(blk_cnt_o), 128'(cntBefore + 1));

        // Illegal strobe on a non-last word: stored as full word, sticky err
        checkOutput("errBefore", 128'(err_o), 128'(0));
        applyStimulus(32'hDEADBEEF, 4'b0101, 1'b0, 1'b0);
        checkOutput("errSet", 128'(err_o), 128'(1));
        for (int i = 0; i < 3; i++)
            applyStimulus(32'h01020304 * 32'(i + 1), 4'b1111, i == 2, 1'b0);
        waitDrain();
        checkOutput("errSticky", 128'(err_o), 128'(1));
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        resetModel();
        #2;
        checkOutput("clearErr", 128'(err_o), 128'(0));
        checkOutput("clearBlkCnt", 128'(blk_cnt_o), 128'(0));
        checkOutput("clearInReady", 128'(in_ready_o), 128'(1));

        // Reset after two accepted words discards the partial block
        applyStimulus(32'hFFEEDDCC, 4'b1111, 1'b0, 1'b1);
        applyStimulus(32'hBBAA9988, 4'b1111, 1'b0, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #2;
        checkOutput("midRstInReady", 128'(in_ready_o), 128'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        resetModel();
        #2;
        checkOutput("midRstOutValid", 128'(out_valid_o), 128'(0));
        checkOutput("midRstOutData", out_data_o, 128'(0));
        checkOutput("midRstOutLast", 128'(out_last_o), 128'(0));
        checkOutput("midRstBlkCnt", 128'(blk_cnt_o), 128'(0));
        for (int i = 0; i < 4; i++)
            applyStimulus(32'h11223344 + 32'(i), 4'b1111, i == 3, 1'b0);
        waitDrain();
        checkOutput("midRstFreshCnt", 128'(blk_cnt_o), 128'(1));

        // Random messages with random ready and enable jitter
        sinkMode = 0;
        jitter   = 1'b1;
        for (int m = 0; m < 25; m++) begin
            nWords = 1 + int'($urandom % 8);
            pad    = 1'($urandom % 2);
            case ($urandom % 4)
                0:       lastStrb = 4'b1000;
                1:       lastStrb = 4'b1100;
                2:       lastStrb = 4'b1110;
                default: lastStrb = 4'b1111;
            endcase
            for (int i = 0; i < nWords; i++)
                applyStimulus($urandom, (i == nWords - 1) ? lastStrb : 4'b1111,
                              i == nWords - 1, pad);
        end
        jitter = 1'b0;
        waitDrain();
        checkOutput("randomBlkCnt", 128'(blk_cnt_o), 128'(16'(tbBlocks)));
        checkOutput("randomErr", 128'(err_o), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
